regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the PicoRV32 system. Successor to the fixed 32x32 dual-port file.
- Adds configurable width, depth and read-port count.
- Adds optional registered read, write-to-read bypass, and hard-wired zero register.
- Adds a post-reset sequential clear engine, so contents are defined without initial blocks (needed for synthesis on Anlogic BRAM/LUTRAM).

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 32, number of entries (>=2; need not be a power of 2).
- NRD, 2, number of independent read ports (1..4).
- REG_READ, 0, 0 = combinational read; 1 = one-cycle registered read.
- BYPASS, 1, 1 = a same-cycle write to the read address forwards wdata to rdata.
- ZERO_R0, 1, 1 = entry 0 always reads 0 and ignores writes.
- Derived localparam AW = clog2(DEPTH), minimum 1.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- raddr  input  NRD*AW  read addresses; port p uses bits [p*AW +: AW].
- rdata  output  NRD*WIDTH  read data; port p uses bits [p*WIDTH +: WIDTH].
- busy  output  1  high while the clear engine runs.

Behaviour:
- Clear FSM has two states: CLEAR and READY.
  - resetn low → state = CLEAR, clr_cnt = 0, busy = 1.
  - In CLEAR with resetn high, each cycle writes mem[clr_cnt] = 0 and increments clr_cnt.
  - When clr_cnt == DEPTH-1 is written → state = READY, busy = 0.
  - busy therefore falls exactly DEPTH rising edges after the first edge sampling resetn = 1.
- Reset asserted mid-clear restarts the clear at entry 0. Reset asserted in READY re-enters CLEAR.
- Writes while busy = 1 are dropped entirely: no memory update, no bypass.
- Writes in READY: mem[waddr] <= wdata on the rising edge when we = 1.
  - Dropped if waddr >= DEPTH.
  - Dropped if ZERO_R0 = 1 and waddr == 0.
- Read data per port p, in priority order:
  1. busy = 1 → 0.
  2. raddr_p >= DEPTH → 0.
  3. ZERO_R0 = 1 and raddr_p == 0 → 0.
  4. BYPASS = 1 and we = 1 and waddr == raddr_p (and the write is not dropped) → wdata.
  5. Otherwise mem[raddr_p].
- REG_READ = 0: rdata is combinational from the current raddr and write inputs.
  - BYPASS = 0 returns the pre-write value in the same cycle.
- REG_READ = 1: rdata is registered with a latency of 1 cycle.
  - The value is computed from raddr, we, waddr and wdata sampled at the edge.
  - With BYPASS = 0, a same-address write returns the old value.
  - rdata registers reset to 0 while resetn is low.
- Reset values: busy = 1; rdata = 0 in both modes, since combinational reads are gated by busy.
- Multiple read ports may use the same address and return identical data. No read port limits any other port.
- Memory array has no reset or initial value. It is defined only through the clear engine.

Decomposition:
- Shared include regfile_defs.vh holds:
  - FSM state encodings RF_CLEAR = 1'b0 and RF_READY = 1'b1.
  - A clog2 function macro, reused by future memory blocks.
- One natural sub-module: regfile_clear_fsm.
  - Parameter: DEPTH.
  - Ports: clk, resetn, busy, clr_we, clr_addr.
  - Owns the state register and counter.
  - regfile_mp muxes clr_we/clr_addr/0 onto the write port while busy.

Test Plan:
- Reset hold 5 cycles, then release, DEPTH = 32 → busy = 1 for exactly 32 edges after release, then 0. Every raddr reads 0 throughout and after the clear.
- READY: write 5 ← 0xDEADBEEF, then read port0 = 5 and port1 = 5 next cycle → both return 0xDEADBEEF. Write to address 0 ← 0x1234, then read 0 → 0 (ZERO_R0 = 1).
- BYPASS = 1, REG_READ = 0: same cycle we = 1, waddr = 7, wdata = 0xA5A5A5A5, raddr0 = 7 → rdata0 = 0xA5A5A5A5 that cycle. Repeat with BYPASS = 0 → old value 0, and the new value appears the following cycle.
- REG_READ = 1: read address 3 holding 0x11 → rdata appears one cycle later. Concurrent write 3 ← 0x22 with BYPASS = 1 → registered 0x22; with BYPASS = 0 → 0x11.
- Assert resetn at clear count 10, hold 1 cycle, release → clear restarts from 0. busy is high for 32 further edges. A write issued during busy (addr 9 ← 0xFF) is dropped: addr 9 reads 0 afterwards.
- DEPTH = 24, NRD = 3, WIDTH = 16: write 23 ← 0xBEEF and write 30 ← 0x1111 → read 23 = 0xBEEF; read 30 = 0 (out of range, write dropped). All three ports read independent addresses correctly in the same cycle.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file family.
//   rf_state_e : clear-engine state encoding (RF_CLEAR / RF_READY)
//   rf_clog2   : ceil(log2(value)), never less than 1, usable in parameter
//                expressions so address widths track DEPTH automatically.
package regfile_mp_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Smallest r >= 1 such that 2**r >= value; bounded loop keeps it static.
    function automatic int rf_clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'sd1 <<< (i - 1)) < value) begin
                r = i;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear engine for regfile_mp.
// After resetn is released it walks every entry 0..DEPTH-1 once, one per
// cycle, asking the owner to write zero there; busy stays high until the
// last entry has been written.
//   clk      : clock, rising edge
//   resetn   : synchronous active-low reset; restarts the walk at entry 0
//   busy     : high while the walk is in progress (and while in reset)
//   clr_we   : write strobe for the zeroing write
//   clr_addr : entry being zeroed this cycle
module regfile_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = rf_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    rf_state_e       state_r;
    rf_state_e       state_s;
    logic [AW-1:0]   cnt_r;
    logic [AW-1:0]   cnt_s;

    // State and counter registers with synchronous reset into CLEAR at entry 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= RF_CLEAR;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: leave CLEAR on the cycle that zeroes the last entry.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            RF_CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_s = RF_READY;
                end else begin
                    cnt_s = cnt_r + AW'(1'b1);
                end
            end
            RF_READY: begin
                state_s = RF_READY;
            end
            default: begin
                state_s = RF_CLEAR;
                cnt_s   = '0;
            end
        endcase
    end

    // Outputs are decoded straight from the registers, so they are glitch-free.
    always_comb begin
        busy     = (state_r == RF_CLEAR);
        clr_we   = (state_r == RF_CLEAR);
        clr_addr = cnt_r;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with one write port.
// Contents are defined only by the post-reset clear engine; reads return 0
// while it runs, and writes during that window are dropped.
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   we     : write enable
//   waddr  : write address (AW bits)
//   wdata  : write data (WIDTH bits)
//   raddr  : NRD packed read addresses, port p at [p*AW +: AW]
//   rdata  : NRD packed read data, port p at [p*WIDTH +: WIDTH]
//   busy   : high while the clear engine is running
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int NRD      = 2,
    parameter  int REG_READ = 0,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_R0  = 1,
    localparam int AW       = rf_clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic                 busy
);

    // DEPTH widened by one bit so non-power-of-two depths compare cleanly.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [0:DEPTH-1];

    logic             busy_s;
    logic             clr_we_s;
    logic [AW-1:0]    clr_addr_s;
    logic             wr_ok_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_addr_s;
    logic [WIDTH-1:0] mem_wdata_s;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear (
        .clk      (clk),
        .resetn   (resetn),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    assign busy = busy_s;

    // A user write lands only when idle, in range, and not aimed at a hard zero.
    always_comb begin
        if (busy_s || !we || ({1'b0, waddr} >= DEPTH_W)) begin
            wr_ok_s = 1'b0;
        end else if ((ZERO_R0 != 0) && (waddr == '0)) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = 1'b1;
        end
    end

    // Write-port mux: the clear engine owns the port while busy.
    always_comb begin
        if (busy_s) begin
            mem_we_s    = clr_we_s;
            mem_addr_s  = clr_addr_s;
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = wr_ok_s;
            mem_addr_s  = waddr;
            mem_wdata_s = wdata;
        end
    end

    // Storage array: deliberately unreset, the clear engine defines it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    idx_s;
        logic [WIDTH-1:0] val_s;

        assign idx_s = raddr[p*AW +: AW];

        // Read priority: busy, out of range, hard zero, bypass, then array.
        always_comb begin
            val_s = '0;
            if (busy_s) begin
                val_s = '0;
            end else if ({1'b0, idx_s} >= DEPTH_W) begin
                val_s = '0;
            end else if ((ZERO_R0 != 0) && (idx_s == '0)) begin
                val_s = '0;
            end else if ((BYPASS != 0) && wr_ok_s && (waddr == idx_s)) begin
                val_s = wdata;
            end else begin
                val_s = mem_r[idx_s];
            end
        end

        if (REG_READ != 0) begin : g_reg
            logic [WIDTH-1:0] rd_r;

            // One-cycle read pipeline register, cleared while in reset.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    rd_r <= '0;
                end else begin
                    rd_r <= val_s;
                end
            end

            assign rdata[p*WIDTH +: WIDTH] = rd_r;
        end else begin : g_comb
            assign rdata[p*WIDTH +: WIDTH] = val_s;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = 5'd0;
    logic [31:0] wdata = 32'h0;
    logic [9:0]  raddr = 10'h0;
    logic [14:0] raddr4 = 15'h0;

    logic [63:0] rd0, rd1, rd2, rd3;
    logic [47:0] rd4;
    logic        busy0, busy1, busy2, busy3, busy4;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.REG_READ(0), .BYPASS(1)) u0 (.clk(clk), .resetn(resetn), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rd0), .busy(busy0));
    regfile_mp #(.REG_READ(0), .BYPASS(0)) u1 (.clk(clk), .resetn(resetn), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rd1), .busy(busy1));
    regfile_mp #(.REG_READ(1), .BYPASS(1)) u2 (.clk(clk), .resetn(resetn), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rd2), .busy(busy2));
    regfile_mp #(.REG_READ(1), .BYPASS(0)) u3 (.clk(clk), .resetn(resetn), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rd3), .busy(busy3));
    regfile_mp #(.WIDTH(16), .DEPTH(24), .NRD(3)) u4 (.clk(clk), .resetn(resetn), .we(we),
        .waddr(waddr), .wdata(wdata[15:0]), .raddr(raddr4), .rdata(rd4), .busy(busy4));

    // Reference model: plain arrays plus "cycles of clearing left" counters.
    logic [31:0] mem32 [0:31];
    logic [15:0] mem24 [0:23];
    int          clr32 = 32;
    int          clr24 = 24;
    logic [63:0] reg_b1 = 64'h0;
    logic [63:0] reg_b0 = 64'h0;

    function automatic logic [31:0] m32_rd(input logic [4:0] a, input bit byp);
        if (clr32 != 0) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && we && waddr == a) return wdata;
        return mem32[a];
    endfunction

    function automatic logic [15:0] m24_rd(input logic [4:0] a);
        if (clr24 != 0) return 16'h0;
        if (a >= 5'd24 || a == 5'd0) return 16'h0;
        if (we && waddr == a) return wdata[15:0];
        return mem24[a];
    endfunction

    always @(posedge clk) begin
        reg_b1 <= resetn ? {m32_rd(raddr[9:5], 1'b1), m32_rd(raddr[4:0], 1'b1)} : 64'h0;
        reg_b0 <= resetn ? {m32_rd(raddr[9:5], 1'b0), m32_rd(raddr[4:0], 1'b0)} : 64'h0;
        if (!resetn) begin
            clr32 <= 32;
            clr24 <= 24;
            for (int i = 0; i < 32; i++) mem32[i] <= 32'h0;
            for (int i = 0; i < 24; i++) mem24[i] <= 16'h0;
        end else begin
            if (clr32 != 0) clr32 <= clr32 - 1;
            else if (we && waddr != 5'd0) mem32[waddr] <= wdata;
            if (clr24 != 0) clr24 <= clr24 - 1;
            else if (we && waddr != 5'd0 && waddr < 5'd24) mem24[waddr] <= wdata[15:0];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rd_byp", rd0, {m32_rd(raddr[9:5], 1'b1), m32_rd(raddr[4:0], 1'b1)});
        chk("rd_nobyp", rd1, {m32_rd(raddr[9:5], 1'b0), m32_rd(raddr[4:0], 1'b0)});
        chk("rd_reg_byp", rd2, reg_b1);
        chk("rd_reg_nobyp", rd3, reg_b0);
        chk("rd_d24", {16'h0, rd4}, {16'h0, m24_rd(raddr4[14:10]), m24_rd(raddr4[9:5]), m24_rd(raddr4[4:0])});
        chk("busy32", {63'h0, busy0}, {63'h0, clr32 != 0});
        chk("busy24", {63'h0, busy4}, {63'h0, clr24 != 0});
    endtask

    // Inputs are changed 1 unit after a rising edge; checks run 1 unit later.
    task automatic tick();
        #1;
        if (armed) check_all();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int n;
        int n4;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        tbl[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[5] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 32'h12345678, 32'h0};
        tbl[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'hCAFEF00D, 32'h12345678};

        // Reset hold for 5 cycles with random read addresses.
        resetn = 1'b0;
        @(posedge clk);
        #1;
        armed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raddr = 10'($urandom);
            tick();
        end
        chk("reset_busy", {63'h0, busy0}, 64'h1);
        chk("reset_rd_comb", rd0, 64'h0);
        chk("reset_rd_reg", rd2, 64'h0);

        // Release and measure the clear duration for both depths.
        resetn = 1'b1;
        n = 0;
        n4 = 0;
        while (busy0 && n < 100) begin
            raddr = 10'($urandom);
            raddr4 = 15'($urandom);
            tick();
            n++;
            if (!busy4 && n4 == 0) n4 = n;
        end
        chk("clear_len32", 64'(n), 64'd32);
        chk("clear_len24", 64'(n4), 64'd24);

        // Table-driven READY-state vectors on the bypassing combinational file.
        for (int i = 0; i < 9; i++) begin
            we = tbl[i].we;
            waddr = tbl[i].wa;
            wdata = tbl[i].wd;
            raddr = {tbl[i].r1, tbl[i].r0};
            #1;
            chk($sformatf("tbl%0d_p0", i), {32'h0, rd0[31:0]}, {32'h0, tbl[i].e0});
            chk($sformatf("tbl%0d_p1", i), {32'h0, rd0[63:32]}, {32'h0, tbl[i].e1});
            if (i == 4) chk("nobyp_old", {32'h0, rd1[31:0]}, 64'h0);
            if (i == 5) chk("nobyp_next", {32'h0, rd1[31:0]}, 64'hA5A5A5A5);
            tick();
        end

        // Registered read latency and same-cycle write behaviour.
        we = 1'b1; waddr = 5'd3; wdata = 32'h11; raddr = {5'd7, 5'd31};
        tick();
        we = 1'b0; raddr = {5'd7, 5'd3};
        #1;
        chk("rr_before", {32'h0, rd2[31:0]}, 64'hCAFEF00D);
        tick();
        chk("rr_latency", {32'h0, rd2[31:0]}, 64'h11);
        we = 1'b1; waddr = 5'd3; wdata = 32'h22;
        tick();
        chk("rr_byp", {32'h0, rd2[31:0]}, 64'h22);
        chk("rr_nobyp", {32'h0, rd3[31:0]}, 64'h11);
        we = 1'b0;

        // Depth-24, three-port file: in-range, out-of-range, independent ports.
        we = 1'b1; waddr = 5'd23; wdata = 32'h0000BEEF;
        tick();
        waddr = 5'd30; wdata = 32'h00001111;
        tick();
        waddr = 5'd12; wdata = 32'h00007777;
        tick();
        we = 1'b0; raddr4 = {5'd12, 5'd30, 5'd23};
        #1;
        chk("d24_ports", {16'h0, rd4}, {16'h0, 16'h7777, 16'h0000, 16'hBEEF});
        tick();

        // Reset in READY, then again at clear count 10; late write while busy.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("midclr_busy", {63'h0, busy0}, 64'h1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n = 0;
        while (busy0 && n < 100) begin
            we = (n == 31);
            waddr = 5'd9;
            wdata = 32'hFF;
            raddr = {5'd9, 5'd9};
            tick();
            n++;
        end
        we = 1'b0;
        chk("clr_restart_len", 64'(n), 64'd32);
        raddr = {5'd9, 5'd9};
        #1;
        chk("busy_write_drop", rd0, 64'h0);
        tick();

        // Randomised traffic against the reference model, with rare resets.
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 150) != 0);
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            raddr = 10'($urandom);
            raddr4 = 15'($urandom);
            if ($urandom_range(0, 3) == 0) raddr[4:0] = waddr;
            if ($urandom_range(0, 3) == 0) raddr4[9:5] = waddr;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
